// File: rtl/jellyvl_divider_pkg.sv
// Shared types and helpers for the divider scheduler and its multicycle core.
package jellyvl_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ZERO  = 2'd3
  } t_sched_state;

  function automatic int unsigned id_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/jellyvl_divider_unsigned_multicycle.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is
// resolved on the accept edge so the result is valid QUOTIENT_WIDTH cycles later.
module jellyvl_divider_unsigned_multicycle #(
  parameter int unsigned DIVIDEND_WIDTH  = 32,
  parameter int unsigned DIVISOR_WIDTH   = 32,
  parameter int unsigned QUOTIENT_WIDTH  = DIVIDEND_WIDTH,
  parameter int unsigned REMAINDER_WIDTH = DIVISOR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cke,
  input  logic [DIVIDEND_WIDTH-1:0]  s_dividend,
  input  logic [DIVISOR_WIDTH-1:0]   s_divisor,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [QUOTIENT_WIDTH-1:0]  m_quotient,
  output logic [REMAINDER_WIDTH-1:0] m_remainder,
  output logic                       m_valid,
  input  logic                       m_ready
);
  localparam int unsigned CNT_WIDTH = $clog2(QUOTIENT_WIDTH + 1);

  typedef logic [DIVIDEND_WIDTH-1:0] t_dividend;
  typedef logic [DIVISOR_WIDTH-1:0]  t_divisor;
  typedef logic [QUOTIENT_WIDTH-1:0] t_quotient;

  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  t_quotient            quo_q, quo_d, step_quo;
  t_divisor             rem_q, rem_d, div_q, div_d, step_rem, step_div;
  logic [DIVISOR_WIDTH:0] shifted, diff;
  logic                 ge;

  assign s_ready     = !running_q && !done_q;
  assign m_valid     = done_q;
  assign m_quotient  = quo_q;
  assign m_remainder = REMAINDER_WIDTH'(rem_q);

  // Iteration operands come straight from the inputs on the accept cycle.
  always_comb begin
    step_rem = running_q ? rem_q : '0;
    step_quo = running_q ? quo_q : QUOTIENT_WIDTH'(t_dividend'(s_dividend));
    step_div = running_q ? div_q : s_divisor;
    shifted  = {step_rem, step_quo[QUOTIENT_WIDTH-1]};
    diff     = shifted - {1'b0, step_div};
    ge       = !diff[DIVISOR_WIDTH];
  end

  always_comb begin
    running_d = running_q;
    done_d    = done_q;
    count_d   = count_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    if ((s_valid && s_ready) || running_q) begin
      quo_d     = {step_quo[QUOTIENT_WIDTH-2:0], ge};
      rem_d     = ge ? diff[DIVISOR_WIDTH-1:0] : shifted[DIVISOR_WIDTH-1:0];
      div_d     = step_div;
      count_d   = running_q ? count_q + 1'b1 : CNT_WIDTH'(1);
      running_d = (count_d != CNT_WIDTH'(QUOTIENT_WIDTH));
      done_d    = !running_d;
    end else if (done_q && m_ready) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
    end else if (cke) begin
      running_q <= running_d;
      done_q    <= done_d;
      count_q   <= count_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
    end
  end

endmodule

// File: rtl/jellyvl_divider_shared_scheduler.sv
// Round-robin sharing of one multicycle unsigned divider among NUM lanes;
// divide-by-zero is answered locally without touching the core.
module jellyvl_divider_shared_scheduler
  import jellyvl_divider_pkg::*;
#(
  parameter int unsigned NUM             = 4,
  parameter int unsigned DIVIDEND_WIDTH  = 32,
  parameter int unsigned DIVISOR_WIDTH   = 32,
  parameter int unsigned QUOTIENT_WIDTH  = DIVIDEND_WIDTH,
  parameter int unsigned REMAINDER_WIDTH = DIVISOR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cke,
  input  logic [NUM*DIVIDEND_WIDTH-1:0] s_dividend,
  input  logic [NUM*DIVISOR_WIDTH-1:0]  s_divisor,
  input  logic [NUM-1:0]            s_valid,
  output logic [NUM-1:0]            s_ready,
  output logic [QUOTIENT_WIDTH-1:0] m_quotient,
  output logic [REMAINDER_WIDTH-1:0] m_remainder,
  output logic                      m_divzero,
  output logic [NUM-1:0]            m_valid,
  input  logic [NUM-1:0]            m_ready,
  output logic                      busy
);
  localparam int unsigned ID_WIDTH = id_width(NUM);

  typedef logic [DIVIDEND_WIDTH-1:0]  t_dividend;
  typedef logic [DIVISOR_WIDTH-1:0]   t_divisor;
  typedef logic [QUOTIENT_WIDTH-1:0]  t_quotient;
  typedef logic [REMAINDER_WIDTH-1:0] t_remainder;

  t_sched_state        state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d, tag_q, tag_d, grant_id;
  t_dividend           zdividend_q, zdividend_d, lane_dividend;
  t_divisor            lane_divisor;
  logic [2*NUM-1:0]    rot;
  logic                grant_found, tag_ready;

  logic       core_s_valid, core_s_ready, core_m_valid, core_m_ready;
  t_quotient  core_quotient;
  t_remainder core_remainder;

  jellyvl_divider_unsigned_multicycle #(
    .DIVIDEND_WIDTH  (DIVIDEND_WIDTH),
    .DIVISOR_WIDTH   (DIVISOR_WIDTH),
    .QUOTIENT_WIDTH  (QUOTIENT_WIDTH),
    .REMAINDER_WIDTH (REMAINDER_WIDTH)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .cke         (cke),
    .s_dividend  (lane_dividend),
    .s_divisor   (lane_divisor),
    .s_valid     (core_s_valid),
    .s_ready     (core_s_ready),
    .m_quotient  (core_quotient),
    .m_remainder (core_remainder),
    .m_valid     (core_m_valid),
    .m_ready     (core_m_ready)
  );

  // Rotate requests so bit k is lane (ptr+k)%NUM; the lowest set bit wins.
  always_comb begin
    rot         = {s_valid, s_valid} >> ptr_q;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (!grant_found && rot[k]) begin
        grant_found = 1'b1;
        grant_id    = ID_WIDTH'((32'(ptr_q) + k) % NUM);
      end
    end
    lane_dividend = '0;
    lane_divisor  = '0;
    tag_ready     = 1'b0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        lane_dividend = s_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        lane_divisor  = s_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
      if (tag_q == ID_WIDTH'(i)) tag_ready = m_ready[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    tag_d        = tag_q;
    zdividend_d  = zdividend_q;
    s_ready      = '0;
    m_valid      = '0;
    m_quotient   = '0;
    m_remainder  = '0;
    m_divzero    = 1'b0;
    core_s_valid = 1'b0;
    core_m_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant only when the handshake can really complete this edge.
        if (grant_found && core_s_ready && cke && !reset) begin
          for (int unsigned i = 0; i < NUM; i++)
            if (grant_id == ID_WIDTH'(i)) s_ready[i] = 1'b1;
          tag_d = grant_id;
          ptr_d = (grant_id == ID_WIDTH'(NUM - 1)) ? '0 : grant_id + 1'b1;
          if (lane_divisor != '0) begin
            core_s_valid = 1'b1;
            state_d      = WAIT;
          end else begin
            zdividend_d = lane_dividend;
            state_d     = ZERO;
          end
        end
      end
      WAIT: begin
        core_m_ready = tag_ready;
        for (int unsigned i = 0; i < NUM; i++)
          if (tag_q == ID_WIDTH'(i)) m_valid[i] = core_m_valid;
        if (core_m_valid) begin
          m_quotient  = core_quotient;
          m_remainder = core_remainder;
          if (tag_ready) state_d = IDLE;
        end
      end
      ZERO: begin
        for (int unsigned i = 0; i < NUM; i++)
          if (tag_q == ID_WIDTH'(i)) m_valid[i] = 1'b1;
        m_quotient  = '1;
        m_remainder = REMAINDER_WIDTH'(zdividend_q);
        m_divzero   = 1'b1;
        if (tag_ready) state_d = IDLE;
      end
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tag_q       <= '0;
      zdividend_q <= '0;
    end else if (cke) begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tag_q       <= tag_d;
      zdividend_q <= zdividend_d;
    end
  end

endmodule
